// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 valid/ready demultiplexer with an independent 2-entry FIFO
// and a saturating accepted-transfer counter per output lane.
module stream_demux_1to4 #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*W-1:0]     out_data,
    input  logic               count_clr,
    output logic [4*CNT_W-1:0] lane_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lane_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lane_state_t        r_state [4];
    logic [W-1:0]       r_head  [4];
    logic [W-1:0]       r_tail  [4];
    logic [CNT_W-1:0]   r_count [4];

    logic [3:0]         w_full;
    logic [3:0]         w_push;
    logic [3:0]         w_pop;
    logic               w_accept;

    // Per-lane handshake decode; in_ready only looks at the selected lane's fill level.
    always_comb begin
        w_push = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_full[i]    = (r_state[i] == FULL);
            out_valid[i] = (r_state[i] != EMPTY);
            w_pop[i]     = out_valid[i] && out_ready[i];
        end
        in_ready = ~w_full[in_sel];
        w_accept = in_valid && ~w_full[in_sel];
        if (w_accept) begin
            w_push[in_sel] = 1'b1;
        end else begin
            w_push = 4'b0000;
        end
    end

    // Pack per-lane head entries and counters onto the flat output buses.
    always_comb begin
        out_data   = '0;
        lane_count = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*W +: W]       = r_head[i];
            lane_count[i*CNT_W +: CNT_W] = r_count[i];
        end
    end

    // Lane FIFOs and counters; a pop never frees space for a same-cycle push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= EMPTY;
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (r_state[i])
                    EMPTY: begin
                        if (w_push[i]) begin
                            r_head[i]  <= in_data;
                            r_state[i] <= ONE;
                        end else begin
                            r_state[i] <= EMPTY;
                        end
                    end
                    ONE: begin
                        case ({w_push[i], w_pop[i]})
                            2'b10: begin
                                r_tail[i]  <= in_data;
                                r_state[i] <= FULL;
                            end
                            2'b01:   r_state[i] <= EMPTY;
                            2'b11:   r_head[i]  <= in_data;
                            default: r_state[i] <= ONE;
                        endcase
                    end
                    FULL: begin
                        if (w_pop[i]) begin
                            r_head[i]  <= r_tail[i];
                            r_state[i] <= ONE;
                        end else begin
                            r_state[i] <= FULL;
                        end
                    end
                    default: r_state[i] <= EMPTY;
                endcase

                if (count_clr) begin
                    r_count[i] <= '0;
                end else if (w_push[i] && (r_count[i] != CNT_MAX)) begin
                    r_count[i] <= r_count[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_count[i] <= r_count[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Bench for stream_demux_1to4: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based lane model.
module tb_stream_demux_1to4;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*W-1:0]     out_data;
    logic               count_clr;
    logic [4*CNT_W-1:0] lane_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q [4][$];
    int           cnt [4];
    logic [W-1:0] last_head [4];
    bit           model_ok = 1'b0;

    stream_demux_1to4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count_clr  (count_clr),
        .lane_count (lane_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance the model.
    task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] ordy, input logic clr, input logic rst);
        bit push;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        count_clr = clr;
        rst_n     = rst;
        @(negedge clk);
        if (model_ok) begin
            chk("in_ready", in_ready, q[s].size() < 2);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("valid%0d", i), out_valid[i], q[i].size() > 0);
                chk($sformatf("data%0d", i), out_data[i*W +: W],
                    (q[i].size() > 0) ? q[i][0] : last_head[i]);
                chk($sformatf("count%0d", i), lane_count[i*CNT_W +: CNT_W], cnt[i]);
            end
        end
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                cnt[i]       = 0;
                last_head[i] = '0;
            end
            model_ok = 1'b1;
        end else begin
            push = v && (q[s].size() < 2);
            for (int i = 0; i < 4; i++) begin
                if (ordy[i] && q[i].size() > 0) void'(q[i].pop_front());
            end
            if (push) q[s].push_back(d);
            for (int i = 0; i < 4; i++) begin
                if (clr) cnt[i] = 0;
                else if (push && s == i && cnt[i] < 255) cnt[i]++;
                if (q[i].size() > 0) last_head[i] = q[i][0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
        out_ready = 4'b0000; count_clr = 1'b0; rst_n = 1'b0;
        #1;
        // Reset, then idle with each select value.
        step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0);
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_data", out_data, 32'h0);
        chk("rst_count", lane_count, 32'h0);
        for (int s = 0; s < 4; s++) step(1'b0, 2'(s), 8'h00, 4'b0000, 1'b0, 1'b1);

        // Basic steer, all consumers ready.
        step(1'b1, 2'd0, 8'h11, 4'b1111, 1'b0, 1'b1);
        chk("steer_lat0", {out_valid[0], out_data[7:0]}, {1'b1, 8'h11});
        step(1'b1, 2'd1, 8'h22, 4'b1111, 1'b0, 1'b1);
        step(1'b1, 2'd2, 8'h33, 4'b1111, 1'b0, 1'b1);
        step(1'b1, 2'd3, 8'h44, 4'b1111, 1'b0, 1'b1);
        chk("steer_lat3", {out_valid[3], out_data[31:24]}, {1'b1, 8'h44});
        chk("steer_count", lane_count, 32'h01010101);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b1);

        // Backpressure on lane 2 with lane 0 unaffected.
        step(1'b1, 2'd2, 8'hA0, 4'b1011, 1'b0, 1'b1);
        step(1'b1, 2'd2, 8'hA1, 4'b1011, 1'b0, 1'b1);
        in_sel = 2'd2;
        #1;
        chk("bp_full", in_ready, 1'b0);
        step(1'b1, 2'd2, 8'hA2, 4'b1011, 1'b0, 1'b1);
        step(1'b1, 2'd0, 8'hB0, 4'b1011, 1'b0, 1'b1);
        chk("bp_iso", {out_valid[0], out_data[7:0], out_data[23:16]}, {1'b1, 8'hB0, 8'hA0});
        step(1'b1, 2'd2, 8'hA2, 4'b1111, 1'b0, 1'b1);
        chk("bp_pop1", out_data[23:16], 8'hA1);
        step(1'b1, 2'd2, 8'hA2, 4'b1111, 1'b0, 1'b1);
        chk("bp_accept", out_data[23:16], 8'hA2);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 1'b1);

        // Streaming 100 words to lane 1.
        for (int k = 0; k < 100; k++) step(1'b1, 2'd1, 8'(k * 7 + 3), 4'b0010, 1'b0, 1'b1);
        chk("stream_count", lane_count[15:8], 8'd100);

        // Counter saturation, clear-wins, then restart.
        for (int k = 0; k < 300; k++) step(1'b1, 2'd3, 8'(k), 4'b1000, 1'b0, 1'b1);
        chk("sat_count", lane_count[31:24], 8'd255);
        step(1'b1, 2'd3, 8'h5A, 4'b1000, 1'b1, 1'b1);
        chk("clr_wins", lane_count[31:24], 8'd0);
        step(1'b1, 2'd3, 8'h5B, 4'b1000, 1'b0, 1'b1);
        chk("after_clr", lane_count[31:24], 8'd1);

        // Reset mid-operation with lanes 0 and 2 full.
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b1);
        step(1'b1, 2'd0, 8'hC0, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 2'd0, 8'hC1, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 2'd2, 8'hD0, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 2'd2, 8'hD1, 4'b0000, 1'b0, 1'b1);
        chk("pre_rst_valid", out_valid, 4'b0101);
        step(1'b1, 2'd1, 8'hEE, 4'b1111, 1'b0, 1'b0);
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_count", lane_count, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 2'(k), 8'h00, 4'b1111, 1'b0, 1'b1);

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 4'($urandom), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to4.md
# stream_demux_1to4

Registered 1-to-4 stream demultiplexer: accepts one valid/ready input stream tagged with a 2-bit lane selector and steers each word to one of four output streams. Each output lane has its own 2-entry buffer, so a stalled lane never blocks traffic to the other lanes. It sits downstream of a producer and fans data out to four consumers, the inverse of the 4-to-1 mux. Per-lane saturating transfer counters support debug and verification.

## Interface
- W, 8, data word width
- CNT_W, 8, width of each per-lane transfer counter
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous to clk, active-low
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word on in_sel's lane this cycle
- in_data  input  W  input word
- in_sel  input  2  destination lane 0..3; sampled together with in_data
- out_valid  output  4  bit i: lane i head entry valid
- out_ready  input  4  bit i: lane i consumer accepts head entry
- out_data  output  4*W  lane i data at bits [i*W +: W]
- count_clr  input  1  synchronous clear of all lane counters
- lane_count  output  4*CNT_W  lane i accepted-transfer count at [i*CNT_W +: CNT_W]

## Operation
- Handshakes: input transfer when in_valid && in_ready; lane i transfer when out_valid[i] && out_ready[i].
- in_ready = ~full[in_sel]. It is combinational from in_sel and lane state only; it never depends on in_valid or out_ready.
- Lane buffer: 2-entry FIFO per lane, states EMPTY(0), ONE(1), FULL(2).
  - EMPTY: on push, go to ONE.
  - ONE: push only, go to FULL; pop only, go to EMPTY; push and pop together, stay in ONE with the new word as head.
  - FULL: pop, go to ONE. No push is possible because in_ready is low.
- Push to a full lane is impossible by construction. A pop in the same cycle does not make room for a push; that costs a one-cycle bubble.
- out_valid[i] = lane i not EMPTY. out_data lane i = head entry.
- While out_valid[i] && !out_ready[i], out_data lane i is held stable.
- Ordering: words on each lane leave in acceptance order. There is no ordering across lanes.
- in_valid with in_ready low: the word is not consumed. The producer may change in_sel or in_data, because the input side is not a sticky AXI-style valid.
- Counters:
  - lane_count[i] increments by 1 on each input transfer to lane i.
  - It saturates at 2^CNT_W-1 and never wraps.
  - count_clr forces all counters to 0. On a clear and a transfer in the same cycle, clear wins and the result is 0.
- Reset (rst_n low at a clk edge): all lanes go to EMPTY and all counters to 0. Words buffered mid-operation are discarded. Reset overrides every simultaneous handshake.

## Timing
- Reset values: out_valid=0, out_data=0 on all lanes, lane_count=0. in_ready=1 for any in_sel.
- Latency: a word accepted at edge N is visible on its lane with out_valid=1 after edge N, i.e. in cycle N+1. There is no combinational in-to-out path.
- Throughput: 1 word/cycle to a single lane when its consumer holds out_ready=1 continuously. The lane stays in ONE with push and pop each cycle.
- Throughput to a lane stuck in FULL: after the lane pops, it accepts again in the following cycle.
- The counter updates on the same edge as the input transfer, so the new value is visible in cycle N+1.
- out_data when out_valid=0: holds the last head value. Only 0 after reset is guaranteed.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, release -> out_valid=4'b0000, all lane_count=0, in_ready=1 for sel 0..3.
- Basic steer: send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 back-to-back, all out_ready=1 -> each word appears exactly one cycle after acceptance on its lane; lane_count = 1,1,1,1.
- Backpressure and isolation:
  - Stimulus: lane 2 out_ready=0; send 0xA0, 0xA1 to lane 2, then a third word to lane 2, then 0xB0 to lane 0.
  - Response: in_ready=0 for the third word while sel=2; the lane 0 word is accepted immediately; lane 2 holds 0xA0 stable.
  - Then release out_ready[2]: the lane pops 0xA0 then 0xA1 in order, and the stalled word is accepted one cycle after the first pop.
- Streaming: 100 consecutive words to lane 1, out_ready[1]=1 -> in_ready never drops, output sequence matches input, lane_count[1]=100.
- Counter edges (CNT_W=8):
  - 300 transfers to lane 3 -> lane_count[3]=255.
  - count_clr asserted in the same cycle as a transfer -> 0 the next cycle.
  - One further transfer -> 1.
- Reset mid-operation: lanes 0 and 2 FULL, assert rst_n=0 for one edge while in_valid=1 and out_ready=4'b1111 -> all out_valid=0, counters 0, and no word is delivered after reset.
